array_a_row_feeder: RTL and testbench

- Sits directly downstream of array_a_addresses_generator.
- Turns its A-buffer address stream into buffer reads, then splits each read word into ARRAY_HEIGHT lanes, one per systolic-array row.
- Applies diagonal skew: lane i is delayed i cycles relative to lane 0.
- Tags each element with an end-of-dot-product flag so PEs know when to close an accumulation.

---
 rtl/matrix_mult_pkg.sv | 33 +++
 rtl/skew_delay_line.sv | 38 +++
 rtl/array_a_row_feeder.sv | 144 ++++++++++++++
 tb/tb_array_a_row_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and constants for the matrix-multiply datapath blocks.
package matrix_mult_pkg;

  // Row feeder control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

  // A-buffer read latency in cycles; the tag stage is sized to match it.
  localparam int unsigned READ_LATENCY = 1;

  // Width of the inner-dimension operand and of the column counter.
  localparam int unsigned COUNT_WIDTH = 16;

  // Default A element width.
  localparam int unsigned ELEM_DATA_WIDTH = 16;

  // One element as it travels down a systolic-array row lane.
  typedef struct packed {
    logic [ELEM_DATA_WIDTH-1:0] data;
    logic                       valid;
    logic                       last;
  } lane_elem_t;

  // Index of the last column in a pass. A zero inner dimension is treated as
  // one so that every element closes its own dot product.
  function automatic logic [COUNT_WIDTH-1:0] last_index(input logic [COUNT_WIDTH-1:0] n_val);
    return (n_val == '0) ? '0 : n_val - 1'b1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to skew one lane of the row feeder.
// DEPTH=0 degenerates to a plain wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    // Clock and reset are intentionally unused when there is no delay.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stages [DEPTH];

    // Shift one stage per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: every stage is reset, not just the head; a stale valid bit left
        // in the middle of the line would otherwise emerge after reset.
        for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      end else begin
        // NOTE: non-blocking assignments let each stage take its neighbour's
        // old value; blocking ones would collapse the line into one register.
        stages[0] <= d;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign q = stages[DEPTH-1];
  end

endmodule

// File: rtl/array_a_row_feeder.sv
// Turns the A-address stream into buffer reads, splits each read word into one
// element per array row, skews lane i by i cycles and tags end-of-dot-product.
module array_a_row_feeder
  import matrix_mult_pkg::*;
#(
  parameter int ARRAY_HEIGHT         = 4,
  parameter int DATA_WIDTH           = 16,
  parameter int BUFFER_ADDRESS_WIDTH = 10
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start_i,
  input  logic [COUNT_WIDTH-1:0]             n,
  input  logic                               addr_valid_i,
  input  logic [BUFFER_ADDRESS_WIDTH-1:0]    addr_i,
  input  logic                               gen_done_i,
  output logic                               mem_rd_en_o,
  output logic [BUFFER_ADDRESS_WIDTH-1:0]    mem_addr_o,
  input  logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] mem_rdata_i,
  output logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] row_data_o,
  output logic [ARRAY_HEIGHT-1:0]            row_valid_o,
  output logic [ARRAY_HEIGHT-1:0]            row_last_o,
  output logic                               busy_o,
  output logic                               done_o
);

  // Lane element packing: {data, valid, last}.
  localparam int LANE_WIDTH = DATA_WIDTH + 2;

  feeder_state_t          state;
  logic [COUNT_WIDTH-1:0] n_r;
  logic [COUNT_WIDTH-1:0] k;
  logic                   accept;
  logic                   k_last;

  // Tag stage outputs, aligned with read data.
  logic [2:0]             tag_d;
  logic [2:0]             tag_q;
  logic                   tag_valid;
  logic                   tag_last;
  logic                   tag_final;

  // Lane-0-aligned register stage and the final-element marker.
  logic [LANE_WIDTH-1:0]  lane_reg [ARRAY_HEIGHT];
  logic                   final_reg;
  logic                   final_out;

  assign accept      = addr_valid_i && (state == RUN);
  assign mem_rd_en_o = accept;
  assign mem_addr_o  = addr_i;
  assign k_last      = (k == last_index(n_r));
  assign busy_o      = (state != IDLE);
  assign done_o      = final_out && (state == DRAIN);

  // Control FSM plus the column counter that decides the last flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      n_r   <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= RUN;
            n_r   <= n;
            k     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            k <= k_last ? '0 : k + 1'b1;
            if (gen_done_i) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done_o) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Carry valid/last/final alongside the outstanding read.
  assign tag_d = {accept, accept && k_last, accept && gen_done_i};

  skew_delay_line #(
    .DEPTH (READ_LATENCY),
    .WIDTH (3)
  ) u_tag (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (tag_d),
    .q       (tag_q)
  );

  assign {tag_valid, tag_last, tag_final} = tag_q;

  // Register the returned word, one element per lane; data is zeroed in
  // bubbles so lanes never carry undefined values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARRAY_HEIGHT; i++) lane_reg[i] <= '0;
      final_reg <= 1'b0;
    end else begin
      for (int i = 0; i < ARRAY_HEIGHT; i++) begin
        lane_reg[i] <= {mem_rdata_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{tag_valid}},
                        tag_valid, tag_last};
      end
      final_reg <= tag_final;
    end
  end

  // Diagonal skew: lane i trails lane 0 by i cycles.
  for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_lane
    logic [LANE_WIDTH-1:0] lane_out;

    skew_delay_line #(
      .DEPTH (i),
      .WIDTH (LANE_WIDTH)
    ) u_skew (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (lane_reg[i]),
      .q       (lane_out)
    );

    assign row_data_o[i*DATA_WIDTH +: DATA_WIDTH] = lane_out[LANE_WIDTH-1:2];
    assign row_valid_o[i]                         = lane_out[1];
    assign row_last_o[i]                          = lane_out[0];
  end

  // The final marker follows the last lane so done lines up with its exit.
  skew_delay_line #(
    .DEPTH (ARRAY_HEIGHT - 1),
    .WIDTH (1)
  ) u_final (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (final_reg),
    .q       (final_out)
  );

endmodule

// File: tb/tb_array_a_row_feeder.sv
// Directed bench for array_a_row_feeder: stimulus pushes expected lane
// elements and done pulses into queues, monitors pop and compare.
module tb_array_a_row_feeder;

  localparam int H  = 4;
  localparam int DW = 16;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start_i = 1'b0;
  logic [15:0]     n = '0;
  logic            addr_valid_i = 1'b0;
  logic [AW-1:0]   addr_i = '0;
  logic            gen_done_i = 1'b0;
  logic            mem_rd_en_o;
  logic [AW-1:0]   mem_addr_o;
  logic [H*DW-1:0] mem_rdata_i = '0;
  logic [H*DW-1:0] row_data_o;
  logic [H-1:0]    row_valid_o;
  logic [H-1:0]    row_last_o;
  logic            busy_o;
  logic            done_o;

  array_a_row_feeder #(
    .ARRAY_HEIGHT         (H),
    .DATA_WIDTH           (DW),
    .BUFFER_ADDRESS_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .n            (n),
    .addr_valid_i (addr_valid_i),
    .addr_i       (addr_i),
    .gen_done_i   (gen_done_i),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .row_data_o   (row_data_o),
    .row_valid_o  (row_valid_o),
    .row_last_o   (row_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer contents: lane i of word a holds a*16 + i + 1, so word 0 is
  // 0x0004_0003_0002_0001.
  function automatic logic [DW-1:0] lane_val(input logic [AW-1:0] a, input int i);
    return 16'(a) * 16'd16 + 16'(i + 1);
  endfunction

  function automatic logic [H*DW-1:0] word_of(input logic [AW-1:0] a);
    logic [H*DW-1:0] w;
    w = '0;
    for (int i = 0; i < H; i++) w[i*DW +: DW] = lane_val(a, i);
    return w;
  endfunction

  // One-cycle-latency A buffer.
  always @(posedge clk) if (mem_rd_en_o) mem_rdata_i <= word_of(mem_addr_o);

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t lane_q [H][$];
  int   done_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lane and done monitors.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      for (int i = 0; i < H; i++) begin
        if (row_valid_o[i]) begin
          if (lane_q[i].size() == 0) begin
            check($sformatf("lane%0d_spurious_valid", i), 64'(row_valid_o[i]), 64'd0);
          end else begin
            e = lane_q[i].pop_front();
            check($sformatf("lane%0d_cycle", i), 64'(cyc), 64'(e.cyc));
            check($sformatf("lane%0d_data", i), 64'(row_data_o[i*DW +: DW]), 64'(e.data));
            check($sformatf("lane%0d_last", i), 64'(row_last_o[i]), 64'(e.last));
          end
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          check("done_spurious", 64'(done_o), 64'd0);
        end else begin
          check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
          check("busy_at_done", 64'(busy_o), 64'd1);
        end
      end
    end
  end

  // Present one cycle of inputs and record what the DUT owes for it.
  task automatic drive(input logic st, input logic [15:0] nv, input logic v,
                       input logic [AW-1:0] a, input logic gd,
                       input logic exp_acc, input logic exp_last);
    exp_t e;
    @(posedge clk);
    #1;
    start_i      = st;
    n            = nv;
    addr_valid_i = v;
    addr_i       = a;
    gen_done_i   = gd;
    #1;
    check("mem_rd_en", 64'(mem_rd_en_o), 64'(exp_acc));
    if (exp_acc) begin
      check("mem_addr", 64'(mem_addr_o), 64'(a));
      for (int i = 0; i < H; i++) begin
        e.cyc  = cyc + 2 + i;
        e.data = lane_val(a, i);
        e.last = exp_last;
        lane_q[i].push_back(e);
      end
      if (gd) done_q.push_back(cyc + 2 + H - 1);
    end
  endtask

  task automatic start_op(input logic [15:0] nv);
    drive(1'b1, nv, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic quiet();
    drive(1'b0, n, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int waited;
    waited = 0;
    while (busy_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_busy_fall"}, 64'(busy_o), 64'd0);
    check({name, "_done_pending"}, 64'(done_q.size()), 64'd0);
    for (int i = 0; i < H; i++)
      check($sformatf("%s_lane%0d_pending", name, i), 64'(lane_q[i].size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_row_valid"}, 64'(row_valid_o), 64'd0);
    check({name, "_row_last"}, 64'(row_last_o), 64'd0);
    check({name, "_row_data"}, 64'(row_data_o), 64'd0);
    check({name, "_busy"}, 64'(busy_o), 64'd0);
    check({name, "_done"}, 64'(done_o), 64'd0);
    check({name, "_rd_en"}, 64'(mem_rd_en_o), 64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Address while idle is dropped.
    drive(1'b0, 16'd0, 1'b1, 10'd7, 1'b0, 1'b0, 1'b0);

    // n=3, addresses 0..5, final on 5: last on elements 2 and 5.
    start_op(16'd3);
    for (int a = 0; a < 6; a++)
      drive(1'b0, 16'd3, 1'b1, AW'(a), a == 5, 1'b1, (a == 2) || (a == 5));
    // Address during drain is dropped.
    drive(1'b0, 16'd3, 1'b1, 10'd9, 1'b0, 1'b0, 1'b0);
    quiet();
    wait_idle("n3");

    // Bubble 1,0,1 with n=2: k only advances on accepted addresses.
    start_op(16'd2);
    drive(1'b0, 16'd2, 1'b1, 10'd10, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd2, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'd2, 1'b1, 10'd11, 1'b1, 1'b1, 1'b1);
    quiet();
    wait_idle("bubble");

    // n=1: every element is last.
    start_op(16'd1);
    drive(1'b0, 16'd1, 1'b1, 10'd20, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 16'd1, 1'b1, 10'd21, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 16'd1, 1'b1, 10'd22, 1'b1, 1'b1, 1'b1);
    quiet();
    wait_idle("n1");

    // n=0 behaves as n=1.
    start_op(16'd0);
    drive(1'b0, 16'd0, 1'b1, 10'd30, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 16'd0, 1'b1, 10'd31, 1'b1, 1'b1, 1'b1);
    quiet();
    wait_idle("n0");

    // start while busy is ignored: n stays 3, k keeps counting.
    start_op(16'd3);
    drive(1'b0, 16'd3, 1'b1, 10'd40, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'd1, 1'b1, 10'd41, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd1, 1'b1, 10'd42, 1'b1, 1'b1, 1'b1);
    quiet();
    wait_idle("restart_ignored");

    // Reset during drain with elements in flight.
    start_op(16'd4);
    drive(1'b0, 16'd4, 1'b1, 10'd50, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd4, 1'b1, 10'd51, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd4, 1'b1, 10'd52, 1'b1, 1'b1, 1'b0);
    quiet();
    @(posedge clk);
    #1 reset_n = 1'b0;
    for (int i = 0; i < H; i++) lane_q[i].delete();
    done_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_all_zero("mid_reset");
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_done", 64'(done_o), 64'd0);
    end

    // Fresh operation after reset.
    start_op(16'd2);
    drive(1'b0, 16'd2, 1'b1, 10'd60, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd2, 1'b1, 10'd61, 1'b1, 1'b1, 1'b1);
    quiet();
    wait_idle("after_reset");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
